// File: rtl/sfx_scheduler_if.sv
// Sound-effect scheduler bus: game state, requests and BGM in,
// mixed per-channel tone frequencies and effect status out.
interface sfx_scheduler_if;
    logic [3:0]  state;
    logic [3:0]  sfx_req;
    logic [31:0] bgm_l;
    logic [31:0] bgm_r;
    logic [31:0] freqL;
    logic [31:0] freqR;
    logic        busy;
    logic [1:0]  cur_id;

    modport master (
        output state, sfx_req, bgm_l, bgm_r,
        input  freqL, freqR, busy, cur_id
    );

    modport slave (
        input  state, sfx_req, bgm_l, bgm_r,
        output freqL, freqR, busy, cur_id
    );
endinterface

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound-effect scheduler with a single pending slot.
// A playing effect overrides BGM on both channels with a 4-note table.
module sfx_scheduler #(
    parameter int unsigned NOTE_CYCLES = 5_000_000
) (
    input  logic           clk,
    input  logic           rst,
    sfx_scheduler_if.slave bus
);

    localparam int CW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NOTE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [1:0]    cur_q, cur_d;
    logic [1:0]    note_q, note_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_id_q, pend_id_d;
    logic [3:0]    prev_q;

    logic          gameplay;
    logic          abort;
    logic          req_ok;
    logic [1:0]    win;
    logic          note_end;
    logic          pv_upd;
    logic [1:0]    pid_upd;

    // Note table; silence is encoded as 1 Hz.
    function automatic logic [31:0] note_freq(
        input logic [1:0] id,
        input logic [1:0] n
    );
        logic [31:0] f;
        case ({id, n})
            4'b00_00: f = 32'd523;
            4'b00_01: f = 32'd659;
            4'b00_10: f = 32'd784;
            4'b01_00: f = 32'd988;
            4'b01_01: f = 32'd1319;
            4'b10_00: f = 32'd196;
            4'b10_01: f = 32'd147;
            4'b11_00: f = 32'd523;
            4'b11_01: f = 32'd659;
            4'b11_10: f = 32'd784;
            4'b11_11: f = 32'd1047;
            default:  f = 32'd1;
        endcase
        return f;
    endfunction

    assign gameplay = (bus.state == 4'd2) ||
                      (bus.state == 4'd4) ||
                      (bus.state == 4'd6);
    assign abort    = (bus.state != prev_q);
    assign req_ok   = gameplay && !abort && (|bus.sfx_req);
    assign note_end = (cnt_q == CNT_LAST);

    // Highest set request bit wins; lower bits are simply dropped.
    always_comb begin
        win = 2'd0;
        if (bus.sfx_req[3])
            win = 2'd3;
        else if (bus.sfx_req[2])
            win = 2'd2;
        else if (bus.sfx_req[1])
            win = 2'd1;
    end

    // Lower-priority request during playback may claim the pending slot.
    always_comb begin
        pv_upd  = pend_valid_q;
        pid_upd = pend_id_q;
        if (fsm_q == PLAY && req_ok && win < cur_q &&
            (!pend_valid_q || win > pend_id_q)) begin
            pv_upd  = 1'b1;
            pid_upd = win;
        end
    end

    // Next-state: abort, then request restart, then note/sequence advance.
    always_comb begin
        fsm_d        = fsm_q;
        cur_d        = cur_q;
        note_d       = note_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        if (abort) begin
            fsm_d        = IDLE;
            cur_d        = 2'd0;
            note_d       = 2'd0;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (req_ok) begin
                        fsm_d  = PLAY;
                        cur_d  = win;
                        note_d = 2'd0;
                        cnt_d  = '0;
                    end
                end
                PLAY: begin
                    pend_valid_d = pv_upd;
                    pend_id_d    = pid_upd;
                    if (req_ok && win >= cur_q) begin
                        cur_d  = win;
                        note_d = 2'd0;
                        cnt_d  = '0;
                    end else if (note_end) begin
                        cnt_d = '0;
                        if (note_q == 2'd3) begin
                            note_d = 2'd0;
                            if (pv_upd) begin
                                cur_d        = pid_upd;
                                pend_valid_d = 1'b0;
                            end else begin
                                fsm_d = IDLE;
                                cur_d = 2'd0;
                            end
                        end else begin
                            note_d = note_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    cur_d = 2'd0;
                end
            endcase
        end
    end

    // State registers; prev_state tracks the game state every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            cur_q        <= 2'd0;
            note_q       <= 2'd0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 2'd0;
            prev_q       <= 4'd0;
        end else begin
            fsm_q        <= fsm_d;
            cur_q        <= cur_d;
            note_q       <= note_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            prev_q       <= bus.state;
        end
    end

    // Output mix: BGM passthrough when idle, table note when playing.
    always_comb begin
        bus.busy   = (fsm_q == PLAY);
        bus.cur_id = cur_q;
        bus.freqL  = bus.bgm_l;
        bus.freqR  = bus.bgm_r;
        if (fsm_q == PLAY) begin
            bus.freqL = note_freq(cur_q, note_q);
            bus.freqR = note_freq(cur_q, note_q);
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with NOTE_CYCLES=4.
// Table-driven basic playback plus hand-written corner sequences.
module tb_sfx_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sfx_scheduler_if bus ();

    sfx_scheduler #(.NOTE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  req;
        logic        busy;
        logic [1:0]  id;
        logic [31:0] fl;
        logic [31:0] fr;
    } vec_t;

    vec_t vt [17];

    int checks = 0;
    int errors = 0;
    logic [31:0] bl = 32'd440;
    logic [31:0] br = 32'd330;

    function automatic logic [31:0] nf(input int id, input int n);
        int t [4][4];
        t[0] = '{523, 659, 784, 1};
        t[1] = '{988, 1319, 1, 1};
        t[2] = '{196, 147, 1, 1};
        t[3] = '{523, 659, 784, 1047};
        return 32'(t[id][n]);
    endfunction

    task automatic tick(input logic [3:0] st, input logic [3:0] rq);
        bus.state   = st;
        bus.sfx_req = rq;
        @(posedge clk);
        #1;
        bus.sfx_req = 4'd0;
    endtask

    task automatic chk(
        input string       nm,
        input logic        eb,
        input logic [1:0]  eid,
        input logic [31:0] el,
        input logic [31:0] er
    );
        checks++;
        if (bus.busy !== eb || bus.cur_id !== eid ||
            bus.freqL !== el || bus.freqR !== er) begin
            errors++;
            $display("FAIL %s: got busy=%0b id=%0d L=%0d R=%0d, want busy=%0b id=%0d L=%0d R=%0d",
                     nm, bus.busy, bus.cur_id, bus.freqL, bus.freqR,
                     eb, eid, el, er);
        end
    endtask

    task automatic run_effect(
        input string      nm,
        input logic [1:0] id,
        input logic [3:0] first
    );
        for (int i = 0; i < 16; i++) begin
            tick(4'd2, (i == 0) ? first : 4'd0);
            chk(nm, 1'b1, id, nf(id, i / 4), nf(id, i / 4));
        end
        tick(4'd2, 4'd0);
        chk({nm, "_end"}, 1'b0, 2'd0, bl, br);
    endtask

    initial begin
        bus.state   = 4'd2;
        bus.sfx_req = 4'd0;
        bus.bgm_l   = bl;
        bus.bgm_r   = br;

        tick(4'd2, 4'd0);
        tick(4'd2, 4'd0);
        chk("reset", 1'b0, 2'd0, bl, br);
        rst = 1'b0;
        tick(4'd2, 4'd1);
        chk("post_reset_abort", 1'b0, 2'd0, bl, br);

        for (int i = 0; i < 16; i++) begin
            vt[i].st   = 4'd2;
            vt[i].req  = (i == 0) ? 4'd1 : 4'd0;
            vt[i].busy = 1'b1;
            vt[i].id   = 2'd0;
            vt[i].fl   = nf(0, i / 4);
            vt[i].fr   = nf(0, i / 4);
        end
        vt[16].st   = 4'd2;
        vt[16].req  = 4'd0;
        vt[16].busy = 1'b0;
        vt[16].id   = 2'd0;
        vt[16].fl   = 32'd440;
        vt[16].fr   = 32'd330;
        for (int i = 0; i < 17; i++) begin
            tick(vt[i].st, vt[i].req);
            chk($sformatf("basic%0d", i), vt[i].busy, vt[i].id,
                vt[i].fl, vt[i].fr);
        end

        for (int i = 0; i < 5; i++) begin
            tick(4'd2, (i == 0) ? 4'd1 : 4'd0);
            chk("pre_e0", 1'b1, 2'd0, nf(0, i / 4), nf(0, i / 4));
        end
        run_effect("preempt", 2'd3, 4'd8);

        tick(4'd2, 4'd4);
        chk("pend_e2", 1'b1, 2'd2, 32'd196, 32'd196);
        tick(4'd2, 4'd2);
        chk("pend_e2", 1'b1, 2'd2, 32'd196, 32'd196);
        tick(4'd2, 4'd1);
        chk("pend_e2", 1'b1, 2'd2, 32'd196, 32'd196);
        for (int i = 3; i < 16; i++) begin
            tick(4'd2, 4'd0);
            chk("pend_e2", 1'b1, 2'd2, nf(2, i / 4), nf(2, i / 4));
        end
        run_effect("chain_e1", 2'd1, 4'd0);

        run_effect("multi", 2'd2, 4'd5);

        tick(4'd2, 4'd8);
        chk("abort_e3", 1'b1, 2'd3, 32'd523, 32'd523);
        tick(4'd2, 4'd2);
        chk("abort_e3", 1'b1, 2'd3, 32'd523, 32'd523);
        tick(4'd2, 4'd0);
        chk("abort_e3", 1'b1, 2'd3, 32'd523, 32'd523);
        bl = 32'd220;
        br = 32'd110;
        bus.bgm_l = bl;
        bus.bgm_r = br;
        tick(4'd3, 4'd8);
        chk("abort", 1'b0, 2'd0, bl, br);
        tick(4'd3, 4'd1);
        chk("nongame_req", 1'b0, 2'd0, bl, br);
        tick(4'd3, 4'd1);
        chk("nongame_req", 1'b0, 2'd0, bl, br);
        tick(4'd2, 4'd0);
        chk("back_to_game", 1'b0, 2'd0, bl, br);
        tick(4'd2, 4'd0);
        chk("pend_cleared", 1'b0, 2'd0, bl, br);

        for (int i = 0; i < 9; i++) begin
            tick(4'd2, (i == 0) ? 4'd1 : 4'd0);
            chk("pre_rst", 1'b1, 2'd0, nf(0, i / 4), nf(0, i / 4));
        end
        rst = 1'b1;
        tick(4'd2, 4'd0);
        chk("mid_rst", 1'b0, 2'd0, bl, br);
        rst = 1'b0;
        tick(4'd2, 4'd1);
        chk("rst_release", 1'b0, 2'd0, bl, br);
        run_effect("after_rst", 2'd0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
